muldiv_unit: RTL and testbench

//   Iterative multiply/divide unit for the execute stage, generalising the fixed 32-bit stalling multiplier.

---
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit producing MIPS-style {hi,lo} results.
// Optional divider datapath: define MULDIV_DIV_EN to build it; otherwise DIV/DIVU return zero.
module muldiv_unit #(
   parameter int WIDTH    = 32,
   parameter int MUL_STEP = 2
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [1:0]       o_dbg_state
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t               r_state, w_next;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_acc, w_acc_step, w_acc_init, w_prod;
   logic [WIDTH-1:0]     r_opnd, r_hi, r_lo, w_res_hi, w_res_lo;
   logic [WIDTH-1:0]     w_abs_a, w_abs_b;
   logic                 r_neg_lo, r_pass;
   logic                 w_accept, w_signed, w_is_div, w_skip;
   logic [WIDTH+MUL_STEP-1:0] w_pp;
`ifdef MULDIV_DIV_EN
   logic                 r_neg_hi, r_is_div, w_qbit;
   logic [WIDTH:0]       w_rem_sh, w_rem_sub;
`endif

   // Handshake: a request is taken on any rising edge where start=1, busy=0 and
   // flush=0; busy stays high until the result cycle, and done marks hi/lo valid.
   assign busy        = (r_state == S_CALC) || (r_state == S_FIX);
   assign done        = (r_state == S_DONE);
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign o_dbg_state = r_state;

   assign w_signed = ~op[0];
   assign w_is_div = op[1];
   assign w_abs_a  = (w_signed && a[WIDTH-1]) ? -a : a;
   assign w_abs_b  = (w_signed && b[WIDTH-1]) ? -b : b;
   assign w_accept = start && !busy && !flush;
`ifdef MULDIV_DIV_EN
   assign w_skip   = w_is_div && (b == '0);
`else
   assign w_skip   = w_is_div;
`endif

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) w_next = w_skip ? S_FIX : S_CALC;
            else          w_next = S_IDLE;
         end
         S_CALC: begin
            if (flush)                  w_next = S_IDLE;
            else if (r_cnt == CW'(1))   w_next = S_FIX;
         end
         S_FIX:   w_next = flush ? S_IDLE : S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   // Multiply: acc holds {partial, multiplier}; MUL_STEP multiplier bits retire per shift.
   always_comb begin
      w_pp = {{MUL_STEP{1'b0}}, r_acc[2*WIDTH-1:WIDTH]};
      for (int k = 0; k < MUL_STEP; k++) begin
         if (r_acc[k]) w_pp = w_pp + ({{MUL_STEP{1'b0}}, r_opnd} << k);
      end
   end

`ifdef MULDIV_DIV_EN
   // Restoring divide: acc holds {remainder, dividend/quotient}, shifting one bit per cycle.
   assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_rem_sub  = w_rem_sh - {1'b0, r_opnd};
   assign w_qbit     = ~w_rem_sub[WIDTH];
   assign w_acc_step = r_is_div ?
                       {(w_qbit ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_qbit} :
                       {w_pp, r_acc[WIDTH-1:MUL_STEP]};
`else
   assign w_acc_step = {w_pp, r_acc[WIDTH-1:MUL_STEP]};
`endif

   always_comb begin
      w_acc_init = {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
`ifdef MULDIV_DIV_EN
      if (w_skip) w_acc_init = {a, {WIDTH{1'b1}}};
`else
      if (w_skip) w_acc_init = '0;
`endif
   end

   assign w_prod = r_neg_lo ? -r_acc : r_acc;

   always_comb begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
      if (r_pass) begin
         w_res_hi = r_acc[2*WIDTH-1:WIDTH];
         w_res_lo = r_acc[WIDTH-1:0];
      end
`ifdef MULDIV_DIV_EN
      else if (r_is_div) begin
         w_res_lo = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
         w_res_hi = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      end
`endif
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_neg_lo <= 1'b0;
         r_pass   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
`ifdef MULDIV_DIV_EN
         r_neg_hi <= 1'b0;
         r_is_div <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_cnt    <= w_is_div ? CW'(WIDTH) : CW'(WIDTH / MUL_STEP);
            r_acc    <= w_acc_init;
            r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
            r_neg_lo <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_pass   <= w_skip;
`ifdef MULDIV_DIV_EN
            r_neg_hi <= w_signed && a[WIDTH-1];
            r_is_div <= w_is_div;
`endif
         end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt - CW'(1);
            r_acc <= w_acc_step;
         end
         if (r_state == S_FIX && !flush) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: spec-level arithmetic model checked every cycle,
// plus hand-computed literals for each directed operation.
module tb_muldiv_unit;

  localparam int W  = 32;
  localparam int MS = 2;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int MUL_LAT = W / MS + 2;
  localparam int DIV_LAT = DIV_EN ? W + 2 : 2;

  logic         sys_clk = 1'b0;
  logic         rst_n   = 1'b0;
  logic         start   = 1'b0;
  logic         flush   = 1'b0;
  logic [1:0]   op      = 2'd0;
  logic [W-1:0] a       = '0;
  logic [W-1:0] b       = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;
  logic [1:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  muldiv_unit #(.WIDTH(W), .MUL_STEP(MS)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .o_dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // spec-level result and latency of one operation
  function automatic void model_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] rh, output logic [W-1:0] rl, output int lat);
    longint sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rh = '0; rl = '0; lat = DIV_LAT;
    case (o)
      2'd0: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; lat = MUL_LAT; end
      2'd1: begin p = 64'(x) * 64'(y); rh = p[63:32]; rl = p[31:0]; lat = MUL_LAT; end
      default: begin
        if (DIV_EN) begin
          if (y == '0) begin
            rl = '1; rh = x; lat = 2;
          end else if (o == 2'd2) begin
            p = sx / sy; rl = p[31:0];
            p = sx % sy; rh = p[31:0];
          end else begin
            rl = x / y; rh = x % y;
          end
        end
      end
    endcase
  endfunction

  // model state: cycles left in flight, and visible outputs
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(posedge sys_clk or negedge rst_n) begin
    int lat;
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (flush) m_left = 0;
        else if (m_left == 1) begin
          m_left = 0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
        end else m_left--;
      end else if (start && !flush) begin
        model_op(op, a, b, p_hi, p_lo, lat);
        m_left = lat - 1;
      end
    end
  end

  // scoreboard compare every cycle
  always @(negedge sys_clk) begin
    chk("busy", 64'(busy), 64'(m_left > 0));
    chk("done", 64'(done), 64'(m_done));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
  end

  // driver tasks
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge sys_clk); #1;
    start = 1'b0;
    a = $urandom_range(1000, 1);
    b = $urandom_range(1000, 1);
    op = 2'($urandom_range(3, 0));
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge sys_clk); #1;
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input int lat, input logic [W-1:0] eh,
                     input logic [W-1:0] el);
    issue(o, x, y);
    wait_done(name, lat);
    chk({name, " hi"}, 64'(hi), 64'(eh));
    chk({name, " lo"}, 64'(lo), 64'(el));
  endtask

  task automatic idle_cycle();
    @(posedge sys_clk); #1;
  endtask

  initial begin
    int n_done;
    logic [W-1:0] cap_hi, cap_lo;

    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    idle_cycle();

    run("mul_neg", 2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 18, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    idle_cycle();
    run("mulu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18, 32'hFFFF_FFFE, 32'h0000_0001);
    // issued in the done cycle: back-to-back accept
    run("divu_100_7", 2'd3, 32'd100, 32'd7, DIV_LAT,
        DIV_EN ? 32'h2 : 32'h0, DIV_EN ? 32'hE : 32'h0);
    run("div_neg", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002, DIV_LAT,
        DIV_EN ? 32'hFFFF_FFFF : 32'h0, DIV_EN ? 32'hFFFF_FFFD : 32'h0);
    idle_cycle();
    run("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT,
        32'h0, DIV_EN ? 32'h8000_0000 : 32'h0);
    run("div_negb", 2'd2, 32'h0000_0007, 32'hFFFF_FFFE, DIV_LAT,
        DIV_EN ? 32'h1 : 32'h0, DIV_EN ? 32'hFFFF_FFFD : 32'h0);
    run("divu_zero", 2'd3, 32'h0000_0005, 32'h0, 2,
        DIV_EN ? 32'h5 : 32'h0, DIV_EN ? 32'hFFFF_FFFF : 32'h0);
    run("div_zero", 2'd2, 32'hFFFF_FFF0, 32'h0, 2,
        DIV_EN ? 32'hFFFF_FFF0 : 32'h0, DIV_EN ? 32'hFFFF_FFFF : 32'h0);
    run("mul_min", 2'd0, 32'h8000_0000, 32'h8000_0000, 18, 32'h4000_0000, 32'h0);
    run("mulu_mid", 2'd1, 32'h1234_5678, 32'h0000_0010, 18, 32'h0000_0001, 32'h2345_6780);
    run("mul_m1", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18, 32'h0, 32'h1);
    idle_cycle();
    run("mul_6_7", 2'd0, 32'd6, 32'd7, 18, 32'h0, 32'h2A);
    idle_cycle();

    // flush at accept+5 together with a start request
    issue(2'd0, 32'd1234, 32'd5678);
    repeat (4) idle_cycle();
    flush = 1'b1; start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd3;
    idle_cycle();
    flush = 1'b0; start = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    n_done = 0;
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1) n_done++;
      idle_cycle();
    end
    chk("flush no done", 64'(n_done), 64'd0);
    chk("flush hi", 64'(hi), 64'h0);
    chk("flush lo", 64'(lo), 64'h2A);
    run("post_flush", 2'd0, 32'd9, 32'hFFFF_FFFF, 18, 32'hFFFF_FFFF, 32'hFFFF_FFF7);

    // start pulsed while busy with differing operands
    issue(2'd0, 32'd3, 32'd5);
    for (int i = 0; i < 10; i++) begin
      start = 1'b1;
      op = 2'($urandom_range(3, 0));
      a = $urandom_range(50000, 1);
      b = $urandom_range(50000, 1);
      idle_cycle();
    end
    start = 1'b0;
    n_done = 0; cap_hi = '1; cap_lo = '1;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) begin
        n_done++; cap_hi = hi; cap_lo = lo;
      end
      idle_cycle();
    end
    chk("ignore start done count", 64'(n_done), 64'd1);
    chk("ignore start hi", 64'(cap_hi), 64'h0);
    chk("ignore start lo", 64'(cap_lo), 64'hF);

    // asynchronous reset mid-CALC
    issue(2'd1, 32'h0000_FFFF, 32'h0000_FFFF);
    repeat (3) @(posedge sys_clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst done", 64'(done), 64'd0);
    chk("async rst hi", 64'(hi), 64'd0);
    chk("async rst lo", 64'(lo), 64'd0);
    chk("async rst state", 64'(dbg_state), 64'd0);
    idle_cycle();
    rst_n = 1'b1;
    idle_cycle();
    run("after_rst", 2'd0, 32'd2, 32'd3, 18, 32'h0, 32'h6);
    repeat (3) idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
